// File: rtl/reliable_sender_pkg.sv
// Shared definitions for the reliable sender and its matching receiver:
// FSM state encoding and the frame checksum.
package reliable_sender_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SEND     = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [1:0] ST_FAIL     = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    SEND     = ST_SEND,
    WAIT_ACK = ST_WAIT_ACK,
    FAIL     = ST_FAIL
  } state_t;

  // Modulo-256 sum of the low nbytes bytes of data plus the sequence number.
  function automatic logic [7:0] frame_checksum(input logic [63:0] data,
                                                input int          nbytes,
                                                input logic [7:0]  seq);
    logic [7:0] sum;
    sum = seq;
    for (int i = 0; i < 8; i++) begin
      if (i < nbytes) sum = sum + data[i*8 +: 8];
    end
    return sum;
  endfunction

endpackage

// File: rtl/rs_timer.sv
// Down-counting ack timer: loaded on transmit, counts while waiting and
// flags expiry on the cycle its count steps from 1 to 0.
module rs_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         expired
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign expired = enable && !load && (count_reg == W'(1));

endmodule

// File: rtl/reliable_sender.sv
// Stop-and-wait frame sender: sequence-numbered, checksummed frames with
// ack/nak handling, timeout retransmission and bounded retries.
module reliable_sender
  import reliable_sender_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int SEQ_W     = 4,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [SEQ_W-1:0]  tx_seq,
  output logic [DATA_W-1:0] tx_data,
  output logic [7:0]        tx_chk,
  input  logic              ack_valid,
  input  logic [SEQ_W-1:0]  ack_seq,
  input  logic              ack_ok,
  output logic              done,
  output logic              fail,
  output logic              busy
);

  localparam int         TIMER_W     = 16;
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT);
  localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRY);

  state_t             state_reg, state_next;
  logic [SEQ_W-1:0]   seq_reg;
  logic [3:0]         retry_reg;
  logic               accept, tx_fire, ack_match, good_ack, retry_evt, can_retry;
  logic               expired;
  logic [63:0]        data_ext;
  logic [7:0]         seq_ext;

  always_comb begin
    data_ext = '0;
    data_ext[DATA_W-1:0] = in_data;
    seq_ext = '0;
    seq_ext[SEQ_W-1:0] = seq_reg;
  end

  assign accept    = (state_reg == IDLE) && in_valid && in_ready;
  assign tx_fire   = (state_reg == SEND) && tx_valid && tx_ready;
  assign ack_match = ack_valid && (ack_seq == seq_reg);
  // A good ack takes priority over a timeout landing on the same cycle.
  assign good_ack  = (state_reg == WAIT_ACK) && ack_match && ack_ok;
  assign retry_evt = (state_reg == WAIT_ACK) && !good_ack && ((ack_match && !ack_ok) || expired);
  assign can_retry = retry_reg < RETRY_LIMIT;

  rs_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tx_fire),
    .load_value (TIMEOUT_VAL),
    .enable     (state_reg == WAIT_ACK),
    .expired    (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (accept) state_next = SEND;
      SEND:     if (tx_fire) state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (good_ack)       state_next = IDLE;
        else if (retry_evt) state_next = can_retry ? SEND : FAIL;
      end
      FAIL:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_reg   <= '0;
      retry_reg <= '0;
    end else begin
      if (good_ack || state_reg == FAIL) seq_reg <= seq_reg + SEQ_W'(1);
      if (accept)                        retry_reg <= '0;
      else if (retry_evt && can_retry)   retry_reg <= retry_reg + 4'd1;
    end
  end

  // Outputs are decoded from the next state so they line up with the state
  // they describe; in_ready waits one settled IDLE cycle after a frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      tx_valid <= 1'b0;
      tx_seq   <= '0;
      tx_data  <= '0;
      tx_chk   <= '0;
      done     <= 1'b0;
      fail     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      in_ready <= (state_reg == IDLE) && (state_next == IDLE);
      tx_valid <= (state_next == SEND);
      done     <= good_ack;
      fail     <= (state_next == FAIL);
      busy     <= (state_next != IDLE);
      if (accept) begin
        tx_seq  <= seq_reg;
        tx_data <= in_data;
        tx_chk  <= frame_checksum(data_ext, DATA_W / 8, seq_ext);
      end
    end
  end

endmodule

// File: tb/tb_reliable_sender.sv
// Scenario bench for reliable_sender: transaction monitor plus a frame-level
// reference model (checksum arithmetic, expected seq, retry/timeout timing).
module tb_reliable_sender;

  localparam int DATA_W    = 16;
  localparam int SEQ_W     = 4;
  localparam int TIMEOUT   = 16;
  localparam int MAX_RETRY = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic [SEQ_W-1:0]  tx_seq;
  logic [DATA_W-1:0] tx_data;
  logic [7:0]        tx_chk;
  logic              ack_valid = 1'b0;
  logic [SEQ_W-1:0]  ack_seq = '0;
  logic              ack_ok = 1'b0;
  logic              done, fail, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          tx_cyc_q[$];
  logic [3:0]  tx_seq_q[$];
  logic [15:0] tx_data_q[$];
  logic [7:0]  tx_chk_q[$];
  int          done_q[$];
  int          fail_q[$];

  reliable_sender #(
    .DATA_W(DATA_W), .SEQ_W(SEQ_W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_seq(tx_seq),
    .tx_data(tx_data), .tx_chk(tx_chk),
    .ack_valid(ack_valid), .ack_seq(ack_seq), .ack_ok(ack_ok),
    .done(done), .fail(fail), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) begin
        tx_cyc_q.push_back(cyc);
        tx_seq_q.push_back(tx_seq);
        tx_data_q.push_back(tx_data);
        tx_chk_q.push_back(tx_chk);
        $display("cyc %0d tx seq=%0d data=%h chk=%h", cyc, tx_seq, tx_data, tx_chk);
      end
      if (done) begin
        done_q.push_back(cyc);
        $display("cyc %0d frame acknowledged", cyc);
      end
      if (fail) begin
        fail_q.push_back(cyc);
        $display("cyc %0d frame abandoned", cyc);
      end
    end
  end

  function automatic logic [7:0] model_chk(input logic [15:0] d, input int s);
    int sum;
    sum = int'(d[15:8]) + int'(d[7:0]) + s;
    return 8'(sum % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    tx_cyc_q.delete(); tx_seq_q.delete(); tx_data_q.delete(); tx_chk_q.delete();
    done_q.delete(); fail_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; ack_valid = 1'b0; tx_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    clear_log();
  endtask

  task automatic send_frame(input logic [15:0] d, output int set_cyc);
    int guard = 0;
    tick();
    while (!in_ready && guard < 200) begin tick(); guard++; end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_frame: in_ready=%0b want 1", in_ready);
    end
    in_valid = 1'b1; in_data = d; set_cyc = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int guard = 0;
    while (tx_cyc_q.size() < n && guard < 200) begin tick(); guard++; end
    checks++;
    if (tx_cyc_q.size() < n) begin
      failures++;
      $display("FAIL wait_tx: frames=%0d want %0d", tx_cyc_q.size(), n);
    end
  endtask

  task automatic pulse_ack(input logic [3:0] s, input logic ok, output int set_cyc);
    ack_valid = 1'b1; ack_seq = s; ack_ok = ok; set_cyc = cyc;
    tick();
    ack_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; ack_valid = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({in_ready, tx_valid, tx_seq, tx_data, tx_chk, done, fail, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0",
               {in_ready, tx_valid, tx_seq, tx_data, tx_chk, done, fail, busy});
    end
    in_valid = 1'b0; ack_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL in_ready_before_edge: got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL in_ready_after_reset: got %b/%b want 1/0", in_ready, busy);
    end
    clear_log();
  endtask

  task automatic test_basic();
    int sc, ac, sc2;
    logic [15:0] d2;
    do_reset();
    send_frame(16'h1234, sc);
    wait_tx(1);
    checks++;
    if (tx_cyc_q[0] !== sc + 1) begin
      failures++; $display("FAIL tx_latency: got %0d want %0d", tx_cyc_q[0], sc + 1);
    end
    checks++;
    if (tx_seq_q[0] !== 4'd0 || tx_data_q[0] !== 16'h1234 || tx_chk_q[0] !== 8'h46) begin
      failures++;
      $display("FAIL basic_frame: got %0d/%h/%h want 0/1234/46", tx_seq_q[0], tx_data_q[0], tx_chk_q[0]);
    end
    repeat (4) tick();
    pulse_ack(4'd0, 1'b1, ac);
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL done_latency: done/in_ready=%b/%b want 1/0", done, in_ready);
    end
    tick();
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL in_ready_latency: done/in_ready=%b/%b want 0/1", done, in_ready);
    end
    d2 = 16'($urandom);
    send_frame(d2, sc2);
    wait_tx(2);
    checks++;
    if (tx_seq_q[1] !== 4'd1 || tx_chk_q[1] !== model_chk(d2, 1)) begin
      failures++;
      $display("FAIL basic_next_seq: got %0d/%h want 1/%h", tx_seq_q[1], tx_chk_q[1], model_chk(d2, 1));
    end
    pulse_ack(4'd1, 1'b1, ac);
    repeat (3) tick();
    checks++;
    if (done_q.size() !== 2 || fail_q.size() !== 0) begin
      failures++; $display("FAIL basic_pulses: done=%0d fail=%0d want 2/0", done_q.size(), fail_q.size());
    end
  endtask

  task automatic test_timeout();
    int sc, ac;
    logic [15:0] d, d2;
    do_reset();
    d = 16'($urandom);
    send_frame(d, sc);
    repeat ((MAX_RETRY + 1) * (TIMEOUT + 1) + 10) tick();
    checks++;
    if (tx_cyc_q.size() !== MAX_RETRY + 1) begin
      failures++; $display("FAIL timeout_tx_count: got %0d want %0d", tx_cyc_q.size(), MAX_RETRY + 1);
    end
    for (int k = 0; k < tx_cyc_q.size(); k++) begin
      checks++;
      if (tx_seq_q[k] !== 4'd0 || tx_data_q[k] !== d || tx_chk_q[k] !== model_chk(d, 0)) begin
        failures++;
        $display("FAIL timeout_retx_fields[%0d]: got %0d/%h/%h want 0/%h/%h",
                 k, tx_seq_q[k], tx_data_q[k], tx_chk_q[k], d, model_chk(d, 0));
      end
      if (k > 0) begin
        checks++;
        if (tx_cyc_q[k] - tx_cyc_q[k-1] !== TIMEOUT + 1) begin
          failures++;
          $display("FAIL timeout_spacing[%0d]: got %0d want %0d", k, tx_cyc_q[k] - tx_cyc_q[k-1], TIMEOUT + 1);
        end
      end
    end
    checks++;
    if (fail_q.size() !== 1 || done_q.size() !== 0) begin
      failures++; $display("FAIL timeout_pulses: fail=%0d done=%0d want 1/0", fail_q.size(), done_q.size());
    end else begin
      checks++;
      if (fail_q[0] !== tx_cyc_q[tx_cyc_q.size()-1] + TIMEOUT + 1) begin
        failures++;
        $display("FAIL timeout_fail_time: got %0d want %0d", fail_q[0], tx_cyc_q[tx_cyc_q.size()-1] + TIMEOUT + 1);
      end
    end
    d2 = 16'($urandom);
    send_frame(d2, sc);
    wait_tx(MAX_RETRY + 2);
    checks++;
    if (tx_seq_q[MAX_RETRY + 1] !== 4'd1) begin
      failures++; $display("FAIL timeout_next_seq: got %0d want 1", tx_seq_q[MAX_RETRY + 1]);
    end
    pulse_ack(4'd1, 1'b1, ac);
    repeat (3) tick();
  endtask

  task automatic test_nak();
    int sc, nc, ac;
    logic [15:0] d;
    do_reset();
    d = 16'($urandom);
    send_frame(d, sc);
    wait_tx(1);
    pulse_ack(4'd0, 1'b0, nc);
    wait_tx(2);
    checks++;
    if (tx_cyc_q[1] !== nc + 1 || tx_seq_q[1] !== 4'd0 || tx_data_q[1] !== d || tx_chk_q[1] !== model_chk(d, 0)) begin
      failures++;
      $display("FAIL nak_retx: cyc=%0d seq=%0d data=%h chk=%h want %0d/0/%h/%h",
               tx_cyc_q[1], tx_seq_q[1], tx_data_q[1], tx_chk_q[1], nc + 1, d, model_chk(d, 0));
    end
    pulse_ack(4'd0, 1'b1, ac);
    repeat (TIMEOUT + 5) tick();
    checks++;
    if (tx_cyc_q.size() !== 2 || done_q.size() !== 1 || fail_q.size() !== 0) begin
      failures++;
      $display("FAIL nak_counts: tx=%0d done=%0d fail=%0d want 2/1/0", tx_cyc_q.size(), done_q.size(), fail_q.size());
    end
  endtask

  task automatic test_wrong_seq();
    int sc, ac;
    do_reset();
    send_frame(16'($urandom), sc);
    wait_tx(1);
    tick(); tick();
    pulse_ack(4'd5, 1'b1, ac);
    wait_tx(2);
    checks++;
    if (tx_cyc_q[1] - tx_cyc_q[0] !== TIMEOUT + 1 || done_q.size() !== 0) begin
      failures++;
      $display("FAIL wrong_seq_ignored: spacing=%0d done=%0d want %0d/0",
               tx_cyc_q[1] - tx_cyc_q[0], done_q.size(), TIMEOUT + 1);
    end
    pulse_ack(4'd0, 1'b1, ac);
    repeat (3) tick();
    checks++;
    if (done_q.size() !== 1) begin
      failures++; $display("FAIL wrong_seq_then_ack: done=%0d want 1", done_q.size());
    end
  endtask

  task automatic test_collision();
    int sc, ac, c;
    do_reset();
    send_frame(16'($urandom), sc);
    wait_tx(1);
    c = tx_cyc_q[0];
    while (cyc < c + TIMEOUT) tick();
    pulse_ack(4'd0, 1'b1, ac);
    repeat (TIMEOUT + 5) tick();
    checks++;
    if (tx_cyc_q.size() !== 1 || done_q.size() !== 1 || fail_q.size() !== 0) begin
      failures++;
      $display("FAIL ack_beats_timeout: tx=%0d done=%0d fail=%0d want 1/1/0",
               tx_cyc_q.size(), done_q.size(), fail_q.size());
    end
    send_frame(16'($urandom), sc);
    wait_tx(2);
    c = tx_cyc_q[1];
    while (cyc < c + TIMEOUT) tick();
    pulse_ack(4'd1, 1'b0, ac);
    repeat ((MAX_RETRY + 1) * (TIMEOUT + 1) + 10) tick();
    checks++;
    if (tx_cyc_q.size() !== 2 + MAX_RETRY || fail_q.size() !== 1 || done_q.size() !== 1) begin
      failures++;
      $display("FAIL nak_timeout_one_retry: tx=%0d fail=%0d done=%0d want %0d/1/1",
               tx_cyc_q.size(), fail_q.size(), done_q.size(), 2 + MAX_RETRY);
    end
  endtask

  task automatic test_back_to_back();
    int sc, ac, exp_seq;
    logic [15:0] d;
    do_reset();
    for (int f = 0; f < 17; f++) begin
      exp_seq = f % 16;
      d = 16'($urandom);
      send_frame(d, sc);
      wait_tx(f + 1);
      checks++;
      if (tx_seq_q[f] !== 4'(exp_seq) || tx_data_q[f] !== d || tx_chk_q[f] !== model_chk(d, exp_seq)) begin
        failures++;
        $display("FAIL wrap_frame[%0d]: got %0d/%h/%h want %0d/%h/%h",
                 f, tx_seq_q[f], tx_data_q[f], tx_chk_q[f], exp_seq, d, model_chk(d, exp_seq));
      end
      repeat ($urandom_range(0, 8)) tick();
      pulse_ack(4'(exp_seq), 1'b1, ac);
    end
    repeat (3) tick();
    checks++;
    if (done_q.size() !== 17 || fail_q.size() !== 0 || tx_cyc_q.size() !== 17) begin
      failures++;
      $display("FAIL wrap_counts: done=%0d fail=%0d tx=%0d want 17/0/17",
               done_q.size(), fail_q.size(), tx_cyc_q.size());
    end
  endtask

  task automatic test_stall_reset();
    int sc, ac, bad;
    logic [15:0] d;
    do_reset();
    tx_ready = 1'b0;
    d = 16'($urandom);
    send_frame(d, sc);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid !== 1'b1 || tx_seq !== 4'd0 || tx_data !== d || tx_chk !== model_chk(d, 0)) bad++;
      tick();
    end
    checks++;
    if (bad !== 0 || tx_cyc_q.size() !== 0) begin
      failures++; $display("FAIL stall_stable: unstable=%0d tx=%0d want 0/0", bad, tx_cyc_q.size());
    end
    tx_ready = 1'b1;
    wait_tx(1);
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, tx_valid, tx_seq, tx_data, tx_chk, done, fail, busy} !== '0) begin
      failures++;
      $display("FAIL async_reset_outputs: got %h want 0",
               {in_ready, tx_valid, tx_seq, tx_data, tx_chk, done, fail, busy});
    end
    tick(); tick();
    rst_n = 1'b1;
    repeat (TIMEOUT + 10) tick();
    checks++;
    if (done_q.size() !== 0 || fail_q.size() !== 0 || tx_cyc_q.size() !== 1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_discards_frame: done=%0d fail=%0d tx=%0d in_ready=%b want 0/0/1/1",
               done_q.size(), fail_q.size(), tx_cyc_q.size(), in_ready);
    end
    d = 16'($urandom);
    send_frame(d, sc);
    wait_tx(2);
    checks++;
    if (tx_seq_q[1] !== 4'd0 || tx_chk_q[1] !== model_chk(d, 0)) begin
      failures++;
      $display("FAIL seq_after_reset: got %0d/%h want 0/%h", tx_seq_q[1], tx_chk_q[1], model_chk(d, 0));
    end
    pulse_ack(4'd0, 1'b1, ac);
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_nak();
    test_wrong_seq();
    test_collision();
    test_back_to_back();
    test_stall_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reliable_sender.md
RELIABLE_SENDER -- requirements
Module: reliable_sender

Interface
REQ-001 SHALL take parameter DATA_W, default 16: payload width in bits; multiple of 8, range 8..64.
REQ-002 SHALL take parameter SEQ_W, default 4: sequence-number width in bits, range 1..8.
REQ-003 SHALL take parameter TIMEOUT, default 16: clk cycles to wait for an ack before retransmitting, range 2..65535.
REQ-004 SHALL take parameter MAX_RETRY, default 3: retransmissions allowed per frame before it is abandoned, range 0..15.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have ports in_valid (input, 1), in_data (input, DATA_W) and in_ready (output, 1): upstream payload handshake.
REQ-008 SHALL have ports tx_valid (output, 1), tx_ready (input, 1), tx_seq (output, SEQ_W), tx_data (output, DATA_W) and tx_chk (output, 8): outgoing frame.
REQ-009 SHALL have ports ack_valid (input, 1), ack_seq (input, SEQ_W) and ack_ok (input, 1): return channel; ack_ok=0 means NAK.
REQ-010 SHALL have ports done (output, 1): one-cycle pulse per acknowledged frame; fail (output, 1): one-cycle pulse per abandoned frame; busy (output, 1): high in every state except IDLE.

Function
REQ-011 SHALL implement the FSM states IDLE, SEND, WAIT_ACK and FAIL.
REQ-012 IDLE: in_ready=1; on in_valid&in_ready SHALL capture in_data, clear the retry count and go to SEND on the next cycle.
REQ-013 in_ready SHALL be 0 in every state except IDLE.
REQ-014 SEND: tx_valid=1, with tx_seq, tx_data and tx_chk held stable until tx_ready=1; on tx_valid&tx_ready SHALL load the timer with TIMEOUT and go to WAIT_ACK.
REQ-015 tx_chk SHALL equal the modulo-256 sum of all DATA_W/8 payload bytes plus seq (zero-extended to 8 bits), registered and valid in the same cycle as tx_valid.
REQ-016 WAIT_ACK: the timer SHALL decrement by 1 each cycle; the timeout event occurs in the cycle the timer reaches 0.
REQ-017 WAIT_ACK, ack_valid & ack_seq==seq & ack_ok: SHALL pulse done, increment seq modulo 2^SEQ_W (wrapping 2^SEQ_W-1 to 0) and go to IDLE.
REQ-018 WAIT_ACK, matching NAK or timeout: if retry count < MAX_RETRY, SHALL increment the retry count and go to SEND, retransmitting the identical seq, data and chk; otherwise SHALL go to FAIL.
REQ-019 FAIL: SHALL pulse fail for one cycle, increment seq modulo 2^SEQ_W and go to IDLE.
REQ-020 An ack whose ack_seq differs from seq SHALL be ignored and SHALL NOT reload the timer.
REQ-021 ack_valid in IDLE, SEND or FAIL SHALL be ignored.
REQ-022 Simultaneous valid ACK and timeout: the ACK SHALL win.
REQ-023 Simultaneous matching NAK and timeout SHALL count as one retry.
REQ-024 With MAX_RETRY=0, the first NAK or timeout SHALL go directly to FAIL.
REQ-025 Latency: tx_valid SHALL rise 1 cycle after the accepting in_valid&in_ready edge; done SHALL rise 1 cycle after the matching ACK; in_ready SHALL rise 2 cycles after that ACK.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, seq=0, retry=0 and timer=0, with outputs in_ready=0, tx_valid=0, tx_seq=0, tx_data=0, tx_chk=0, done=0, fail=0 and busy=0.
REQ-027 in_ready SHALL rise in the first clk cycle after rst_n deasserts.
REQ-028 Reset asserted mid-frame SHALL discard the frame without pulsing done or fail.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (2-bit localparams) and the checksum function.
REQ-030 The timeout counter SHALL be a sub-module rs_timer (load, enable, expired), reusable by the matching receiver.
REQ-031 All outputs SHALL be registered, with no combinational path from ack_* to tx_*.

Verification (DATA_W=16, SEQ_W=4, TIMEOUT=16, MAX_RETRY=3)
REQ-032 Stimulus: in_data=16'h1234 with tx_ready held at 1, then ACK seq 0 ok 5 cycles later -> tx_chk=8'h46, done pulses once, next frame carries seq 1.
REQ-033 Stimulus: no ACK ever -> 4 transmissions of seq 0 spaced TIMEOUT+1 cycles apart, then a single fail pulse, next frame carries seq 1.
REQ-034 Stimulus: NAK seq 0, then ACK seq 0 ok -> exactly 2 transmissions, done pulses once, fail never pulses.
REQ-035 Stimulus: ACK with seq 5 while seq=0 is outstanding -> ignored, retransmission occurs on timeout.
REQ-036 Stimulus: send 17 frames, each ACKed -> seq runs 0..15 then wraps to 0.
REQ-037 Stimulus: tx_ready held at 0 for 10 cycles, then rst_n pulsed low in WAIT_ACK -> frame fields stay stable throughout the stall; after reset all outputs are 0, seq=0, no done or fail pulse.
